// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_pkg                                                     |
// | Brief  : Shared types and constants for the AES-128 key expander     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_EMIT = 2'd1;
  localparam logic [1:0] C_ST_SUB  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = C_ST_IDLE,
    ST_EMIT = C_ST_EMIT,
    ST_SUB  = C_ST_SUB
  } state_e;

  // Zero-based: rcon_byte(0) is the constant used to derive round key 1.
  function automatic logic [7:0] rcon_byte(input logic [3:0] i_idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 10; k++) begin
      if (i_idx == 4'(k)) r = RCON[k];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_subword.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_subword                                                 |
// | Brief  : SubWord over LANES S-boxes; serial mode gathers 4 bytes     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module aes_subword
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  word_t      i_word,
  input  logic [1:0] i_cnt,
  input  logic       i_en,
  output word_t      o_word
);

  generate
    if (LANES == 1) begin : g_serial
      logic [7:0]  w_in;
      logic [7:0]  w_out;
      logic [23:0] r_acc;

      // MSB byte first, so after three shifts r_acc holds bytes 0..2 in order.
      always_comb begin
        w_in = i_word[31:24];
        case (i_cnt)
          2'd0:    w_in = i_word[31:24];
          2'd1:    w_in = i_word[23:16];
          2'd2:    w_in = i_word[15:8];
          default: w_in = i_word[7:0];
        endcase
      end

      sbox u_sbox (
        .i_byte (w_in),
        .o_byte (w_out)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (i_en) begin
          r_acc <= {r_acc[15:0], w_out};
        end
      end

      assign o_word = {r_acc, w_out};
    end else begin : g_parallel
      logic w_unused;
      assign w_unused = ^{clk, rst_n, i_cnt, i_en};

      for (genvar g = 0; g < 4; g++) begin : g_lane
        sbox u_sbox (
          .i_byte (i_word[8*g +: 8]),
          .o_byte (o_word[8*g +: 8])
        );
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sbox                                                        |
// | Brief  : AES forward S-box, purely combinational lookup              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = C_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_key_expand                                              |
// | Brief  : AES-128 key schedule, streams round keys 0..10 with         |
// |          valid/ready. Define KEYEXP_STORE_EN to add an 11-entry      |
// |          round-key store with a combinational read port.             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int SUBWORD_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
`ifdef KEYEXP_STORE_EN
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
`endif
  output logic         busy
);

  localparam int         C_SUB_CYCLES = (SUBWORD_LANES == 1) ? 4 : 1;
  localparam logic [1:0] C_SUB_LAST   = 2'(C_SUB_CYCLES - 1);

  state_e       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic [1:0]   r_cnt;

  word_t        w_w0, w_w1, w_w2, w_w3;
  word_t        w_rot, w_sub, w_t;
  word_t        w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next_key;
  logic         w_sub_en;
  logic         w_sub_last;
  logic         w_key_acc;

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  assign w_sub_en   = (r_state == ST_SUB);
  assign w_sub_last = w_sub_en && (r_cnt == C_SUB_LAST);
  assign w_key_acc  = (r_state == ST_IDLE) && key_valid;

  aes_subword #(
    .LANES (SUBWORD_LANES)
  ) u_subword (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_word (w_rot),
    .i_cnt  (r_cnt),
    .i_en   (w_sub_en),
    .o_word (w_sub)
  );

  assign w_t  = w_sub ^ {rcon_byte(r_idx), 24'h000000};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            r_key   <= key_in;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // SUB is only entered below NR, so r_idx never passes 10.
          if (rk_ready) begin
            r_state <= (r_idx == NR) ? ST_IDLE : ST_SUB;
          end
        end
        ST_SUB: begin
          if (w_sub_last) begin
            r_key   <= w_next_key;
            r_idx   <= r_idx + 4'd1;
            r_cnt   <= '0;
            r_state <= ST_EMIT;
          end else begin
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_ready = (r_state == ST_IDLE);
  assign rk_valid  = (r_state == ST_EMIT);
  assign rk_out    = r_key;
  assign rk_idx    = r_idx;
  assign busy      = (r_state != ST_IDLE);

`ifdef KEYEXP_STORE_EN
  logic [127:0] r_store [0:10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 11; k++) r_store[k] <= '0;
    end else if (w_key_acc) begin
      for (int k = 1; k < 11; k++) r_store[k] <= '0;
      r_store[0] <= key_in;
    end else if (w_sub_last) begin
      for (int k = 1; k < 11; k++) begin
        if (4'(k) == r_idx + 4'd1) r_store[k] <= w_next_key;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    for (int k = 0; k < 11; k++) begin
      if (rd_idx == 4'(k)) rd_key = r_store[k];
    end
  end
`else
  logic w_unused_acc;
  assign w_unused_acc = w_key_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// Scoreboard bench: a 4-lane and a 1-lane expander share stimulus; a negedge
// monitor checks every round-key handshake, stall hold and output spacing.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         rk_ready = 1'b1;
  logic [127:0] key_in = '0;

  logic         d4_key_ready, d4_rk_valid, d4_busy;
  logic [127:0] d4_rk_out;
  logic [3:0]   d4_rk_idx;
  logic         d1_key_ready, d1_rk_valid, d1_busy;
  logic [127:0] d1_rk_out;
  logic [3:0]   d1_rk_idx;
`ifdef KEYEXP_STORE_EN
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] d4_rd_key, d1_rd_key;
`endif

  always #5 clk = ~clk;

  aes_key_expand #(.SUBWORD_LANES(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (d4_key_ready),
    .key_in    (key_in),
    .rk_valid  (d4_rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (d4_rk_out),
    .rk_idx    (d4_rk_idx),
`ifdef KEYEXP_STORE_EN
    .rd_idx    (rd_idx),
    .rd_key    (d4_rd_key),
`endif
    .busy      (d4_busy)
  );

  aes_key_expand #(.SUBWORD_LANES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (d1_key_ready),
    .key_in    (key_in),
    .rk_valid  (d1_rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (d1_rk_out),
    .rk_idx    (d1_rk_idx),
`ifdef KEYEXP_STORE_EN
    .rd_idx    (rd_idx),
    .rd_key    (d1_rd_key),
`endif
    .busy      (d1_busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    bit           chk;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cur_vec = 0;

  logic [127:0] rk_fips [0:10];
  logic [127:0] key2, key2_rk10;

  bit           pend     [0:1];
  int           pend_cyc [0:1];
  int           gap_exp  [0:1];
  bit           hold_p   [0:1];
  logic [127:0] hold_k   [0:1];
  logic [3:0]   hold_i   [0:1];
  int           acc_cnt  [0:1];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic push_exp(input int d);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx = 4'(i);
      if (cur_vec == 0) begin
        e.key = rk_fips[i];
        e.chk = 1'b1;
      end else begin
        e.key = (i == 0) ? key2 : key2_rk10;
        e.chk = (i == 0) || (i == 10);
      end
      if (d == 0) q4.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic kr, input logic rv,
                     input logic [127:0] ro, input logic [3:0] ri);
    exp_t  e;
    bit    empty;
    string tag;
    tag = (d == 0) ? "L4" : "L1";
    if (pend[d] && rv) begin
      chk({tag, "_spacing"}, 128'(cyc - pend_cyc[d]), 128'(gap_exp[d]));
      pend[d] = 1'b0;
    end
    if (hold_p[d]) begin
      chk({tag, "_hold_valid"}, 128'(rv), 128'(1));
      chk({tag, "_hold_key"}, ro, hold_k[d]);
      chk({tag, "_hold_idx"}, 128'(ri), 128'(hold_i[d]));
    end
    hold_p[d] = rv && !rk_ready;
    hold_k[d] = ro;
    hold_i[d] = ri;
    if (key_valid && kr) begin
      push_exp(d);
      pend[d]     = 1'b1;
      pend_cyc[d] = cyc;
      gap_exp[d]  = 1;
      acc_cnt[d]++;
    end
    if (rv && rk_ready) begin
      empty = (d == 0) ? (q4.size() == 0) : (q1.size() == 0);
      if (empty) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_unexpected_rk: got idx %0d expected none", tag, ri);
      end else begin
        if (d == 0) e = q4.pop_front();
        else        e = q1.pop_front();
        chk({tag, "_rk_idx"}, 128'(ri), 128'(e.idx));
        if (e.chk) chk({tag, "_rk_key"}, ro, e.key);
      end
      if (ri != 4'd10) begin
        pend[d]     = 1'b1;
        pend_cyc[d] = cyc;
        gap_exp[d]  = (d == 0) ? 2 : 5;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        pend[d]   = 1'b0;
        hold_p[d] = 1'b0;
      end
    end else begin
      mon(0, d4_key_ready, d4_rk_valid, d4_rk_out, d4_rk_idx);
      mon(1, d1_key_ready, d1_rk_valid, d1_rk_out, d1_rk_idx);
    end
  end

  task automatic send_key(input logic [127:0] k);
    @(posedge clk);
    #1;
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!d4_busy && !d1_busy) return;
    end
    fail_now(name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_L4_key_ready"}, 128'(d4_key_ready), 128'(1));
    chk({tag, "_L4_rk_valid"},  128'(d4_rk_valid),  128'(0));
    chk({tag, "_L4_rk_out"},    d4_rk_out,          128'(0));
    chk({tag, "_L4_rk_idx"},    128'(d4_rk_idx),    128'(0));
    chk({tag, "_L4_busy"},      128'(d4_busy),      128'(0));
    chk({tag, "_L1_key_ready"}, 128'(d1_key_ready), 128'(1));
    chk({tag, "_L1_rk_valid"},  128'(d1_rk_valid),  128'(0));
    chk({tag, "_L1_rk_out"},    d1_rk_out,          128'(0));
    chk({tag, "_L1_busy"},      128'(d1_busy),      128'(0));
  endtask

  initial begin
    bit found;
    rk_fips = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    key2      = 128'h000102030405060708090a0b0c0d0e0f;
    key2_rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // FIPS-197 key, consumer always ready
    cur_vec = 0;
    send_key(rk_fips[0]);
    wait_idle("fips_idle");
    chk("fips_L4_drained", 128'(q4.size()), 128'(0));
    chk("fips_L1_drained", 128'(q1.size()), 128'(0));
    chk("fips_L4_back_idle", 128'(d4_key_ready), 128'(1));
`ifdef KEYEXP_STORE_EN
    rd_idx = 4'd10;
    #1;
    chk("store_rd10", d4_rd_key, rk_fips[10]);
    chk("store_L1_rd10", d1_rd_key, rk_fips[10]);
    rd_idx = 4'd1;
    #1;
    chk("store_rd1", d4_rd_key, rk_fips[1]);
    rd_idx = 4'd12;
    #1;
    chk("store_rd12", d4_rd_key, 128'(0));
    rd_idx = 4'd0;
`endif

    // Seven-cycle stall on round key 3 of the 4-lane instance
    send_key(rk_fips[0]);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (d4_rk_valid && d4_rk_idx == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("stall_find_rk3");
    rk_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("stall_L4_idx_held", 128'(d4_rk_idx), 128'(3));
    rk_ready = 1'b1;
    wait_idle("stall_idle");
    chk("stall_L4_drained", 128'(q4.size()), 128'(0));
    chk("stall_L1_drained", 128'(q1.size()), 128'(0));

    // key_valid held high across a busy period
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    @(posedge clk);
    #1;
    key_in    = rk_fips[0];
    key_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    key_valid = 1'b0;
    wait_idle("held_idle");
    chk("held_L4_accepts", 128'(acc_cnt[0]), 128'(2));
    chk("held_L1_accepts", 128'(acc_cnt[1]), 128'(1));
    chk("held_L4_drained", 128'(q4.size()), 128'(0));
    chk("held_L1_drained", 128'(q1.size()), 128'(0));

    // Reset in the middle of SUB for round 5
    send_key(rk_fips[0]);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (d4_busy && !d4_rk_valid && d4_rk_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("abort_find_sub5");
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    q4.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    cur_vec = 1;
    send_key(key2);
    wait_idle("key2_idle");
    chk("key2_L4_drained", 128'(q4.size()), 128'(0));
    chk("key2_L1_drained", 128'(q1.size()), 128'(0));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter SUBWORD_LANES, default 4, number of sbox instances used for SubWord; legal values are 1 and 4 only.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port key_valid  in  1  cipher key offered.
REQ-005 SHALL have port key_ready  out  1  block accepts a cipher key.
REQ-006 SHALL have port key_in  in  128  AES-128 key; key_in[127:120] is key byte 0 (MSB of w0).
REQ-007 SHALL have port rk_valid  out  1  round key presented.
REQ-008 SHALL have port rk_ready  in  1  consumer accepts the round key.
REQ-009 SHALL have port rk_out  out  128  round key, same byte order as key_in.
REQ-010 SHALL have port rk_idx  out  4  round index 0..10 of rk_out.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, EMIT, SUB.
REQ-013 IDLE: key_ready=1, rk_valid=0; on key_valid&&key_ready, SHALL register key_in as round key 0, set idx=0, and go to EMIT.
REQ-014 EMIT: rk_valid=1, rk_out=current key, rk_idx=idx, key_ready=0.
REQ-015 EMIT on rk_ready: if idx==10, go to IDLE; else go to SUB.
REQ-016 rk_out/rk_idx SHALL hold stable while rk_valid=1 and rk_ready=0, for unbounded stall.
REQ-017 SUB SHALL compute t = SubWord(RotWord(w3)) ^ {RCON[idx+1],24'h0}.
  - SUB lasts 4/SUBWORD_LANES cycles; each cycle substitutes SUBWORD_LANES bytes.
  - On the last SUB cycle: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; idx increments; go to EMIT.
REQ-018 Latency:
  - Round key 0 valid the cycle after key handshake.
  - Round key i+1 valid 2 cycles after the handshake of key i with SUBWORD_LANES=4, 5 cycles with SUBWORD_LANES=1.
REQ-019 key_valid outside IDLE SHALL be ignored; no key is dropped silently because key_ready=0.
REQ-020 A key handshake in the same cycle as the final rk handshake SHALL NOT occur (key_ready=0 in EMIT); the new key is accepted on the following IDLE cycle.
REQ-021 The idx counter SHALL never exceed 10; 4-bit values 11..15 are unreachable.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, idx=0, rk_out=0, rk_valid=0, busy=0, key_ready=1 (key_ready=1 once out of reset), and clear the SUB sub-cycle counter.
REQ-023 Reset during EMIT or SUB SHALL abort the expansion; no further round keys of that key are emitted.

Configuration
REQ-024 With macro KEYEXP_STORE_EN defined, the block SHALL:
  - add ports rd_idx in 4 and rd_key out 128;
  - store each round key in an 11-entry register file at its EMIT entry;
  - drive rd_key combinationally from entry rd_idx, and 0 for rd_idx>10;
  - clear all entries on reset and on each new key acceptance.
REQ-025 Without KEYEXP_STORE_EN, those ports and the storage SHALL be absent; behaviour is streaming only.

Structure
REQ-026 Package aes_pkg SHALL hold: the RCON table (01,02,04,08,10,20,40,80,1b,36), the FSM state enum, a 32-bit word typedef, and the constant NR=10.
REQ-027 Sub-module aes_subword SHALL wrap SUBWORD_LANES instances of the existing sbox module and select bytes by sub-cycle count; the FSM and key registers stay in aes_key_expand.

Verification
REQ-028 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk 0..10 in order;
  - rk1 = a0fafe1788542cb123a339392a6c7605;
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - then IDLE.
REQ-029 Backpressure: rk_ready low for 7 cycles on rk3 -> rk_out/rk_idx=3 held constant, no skipped or duplicated index.
REQ-030 SUBWORD_LANES=1, same key -> identical 11 keys with 5-cycle spacing; SUBWORD_LANES=4 -> 2-cycle spacing.
REQ-031 rst_n low during SUB of round 5 -> outputs 0 immediately; after release, key 000102030405060708090a0b0c0d0e0f expands to rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 KEYEXP_STORE_EN build: after the FIPS key completes, rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, rd_idx=12 -> 0; key_valid held high during busy -> accepted only after IDLE.
